// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared states, opcodes and round-robin pick for alu_arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  // First valid requester after 'last', wrapping at nreq-1; returns 'last' when none is valid.
  function automatic int rr_next_grant(input logic [7:0] valid, input int last, input int nreq);
    int  pick;
    int  idx;
    logic hit;
    pick = last;
    hit  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = (last + k) % nreq;
      if (k <= nreq && !hit && valid[idx[2:0]]) begin
        pick = idx;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational N-bit ALU; division/modulo by zero yields 0
import alu_arb_pkg::*;

module alu #(
  parameter int N = 8
) (
  input  logic [2:0]   sel,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic         Z
);

  always_comb begin
    C = A;
    case (sel)
      OP_ADD: C = A + B;
      OP_SUB: C = A - B;
      OP_MUL: C = A * B;
      OP_DIV: C = (B == '0) ? '0 : A / B;
      OP_MOD: C = (B == '0) ? '0 : A % B;
      default: C = A;
    endcase
  end

  assign Z = (C == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter in front of a shared ALU (IDLE/EXEC/RESP)
// Optional ALU_ARB_DIVZERO_EN: flag div/mod by zero on rsp_err and force rsp_c to all ones.
import alu_arb_pkg::*;

module alu_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req_valid,
  output logic [NREQ-1:0]                       req_ready,
  input  logic [3*NREQ-1:0]                     req_sel,
  input  logic [N*NREQ-1:0]                     req_a,
  input  logic [N*NREQ-1:0]                     req_b,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [$clog2(NREQ > 1 ? NREQ : 2)-1:0] rsp_id,
  output logic [N-1:0]                          rsp_c,
  output logic                                  rsp_z,
  output logic                                  rsp_err
);

  localparam int IDW = $clog2(NREQ > 1 ? NREQ : 2);

  state_t          r_state;
  state_t          w_next_state;
  logic [IDW-1:0]  r_last_grant;
  logic [IDW-1:0]  w_gidx;
  logic [NREQ-1:0] w_ready;
  logic            w_hs;

  logic [2:0]      r_sel;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [IDW-1:0]  r_id;

  logic            r_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [N-1:0]    r_c;
  logic            r_z;
  logic            r_err;

  logic [N-1:0]    w_c;
  logic            w_z;
  logic [N-1:0]    w_c_final;
  logic            w_z_final;
  logic            w_err;

  assign w_gidx = IDW'(rr_next_grant(8'(req_valid), int'(r_last_grant), NREQ));
  assign w_hs   = (r_state == IDLE) && (|req_valid);

  always_comb begin
    w_next_state = r_state;
    w_ready      = '0;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_ready[w_gidx] = 1'b1;
          w_next_state    = EXEC;
        end
      end
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  alu #(.N(N)) u_alu (
    .sel (r_sel),
    .A   (r_a),
    .B   (r_b),
    .C   (w_c),
    .Z   (w_z)
  );

`ifdef ALU_ARB_DIVZERO_EN
  logic w_divz;
  assign w_divz    = ((r_sel == OP_DIV) || (r_sel == OP_MOD)) && (r_b == '0);
  assign w_c_final = w_divz ? '1 : w_c;
  assign w_z_final = w_divz ? 1'b0 : w_z;
  assign w_err     = w_divz;
`else
  assign w_c_final = w_c;
  assign w_z_final = w_z;
  assign w_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_sel        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_valid      <= 1'b0;
      r_rsp_id     <= '0;
      r_c          <= '0;
      r_z          <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_hs) begin
        r_sel        <= req_sel[3*w_gidx +: 3];
        r_a          <= req_a[N*w_gidx +: N];
        r_b          <= req_b[N*w_gidx +: N];
        r_id         <= w_gidx;
        r_last_grant <= w_gidx;
      end
      // Response registers only move in EXEC so they stay stable through RESP and IDLE.
      if (r_state == EXEC) begin
        r_valid  <= 1'b1;
        r_rsp_id <= r_id;
        r_c      <= w_c_final;
        r_z      <= w_z_final;
        r_err    <= w_err;
      end else if (r_state == RESP && rsp_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_c     = r_c;
  assign rsp_z     = r_z;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_sel;
  logic [N*NREQ-1:0]    req_a;
  logic [N*NREQ-1:0]    req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [N-1:0]         rsp_c;
  logic                 rsp_z;
  logic                 rsp_err;

  int n_pass  = 0;
  int n_total = 0;

  alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .rsp_z     (rsp_z),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    req_sel[3*idx +: 3] = sel;
    req_a[8*idx +: 8]   = a;
    req_b[8*idx +: 8]   = b;
  endtask

  task automatic run_op(input string tag, input int idx, input logic [2:0] sel,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_c, input logic exp_z);
    set_req(idx, sel, a, b);
    req_valid = 4'(1 << idx);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = '0;
    check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(idx));
    check({tag, "_c"}, 32'(rsp_c), 32'(exp_c));
    check({tag, "_z"}, 32'(rsp_z), 32'(exp_z));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};

    rst       = 1'b1;
    req_valid = '0;
    req_sel   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_c", 32'(rsp_c), 32'd0);
    check("reset_z", 32'(rsp_z), 32'd0);
    check("reset_id", 32'(rsp_id), 32'd0);
    check("reset_err", 32'(rsp_err), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);

    run_op("add_5_7", 2, 3'b000, 8'd5, 8'd7, 8'd12, 1'b0);
    run_op("sub_eq", 1, 3'b001, 8'd3, 8'd3, 8'd0, 1'b1);
    run_op("sub_wrap", 3, 3'b001, 8'd0, 8'd1, 8'hFF, 1'b0);
    run_op("mul_trunc", 0, 3'b010, 8'd20, 8'd13, 8'd4, 1'b0);
    run_op("div", 2, 3'b011, 8'd100, 8'd7, 8'd14, 1'b0);
    run_op("mod", 1, 3'b100, 8'd100, 8'd7, 8'd2, 1'b0);
    run_op("pass_a", 3, 3'b111, 8'h5A, 8'h33, 8'h5A, 1'b0);

    set_req(0, 3'b011, 8'd9, 8'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    check("divz_valid", 32'(rsp_valid), 32'd1);
`ifdef ALU_ARB_DIVZERO_EN
    check("divz_err", 32'(rsp_err), 32'd1);
    check("divz_c", 32'(rsp_c), 32'hFF);
    check("divz_z", 32'(rsp_z), 32'd0);
`else
    check("divz_err", 32'(rsp_err), 32'd0);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'b000, 8'(i + 1), 8'd10);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rr%0d_grant", g), 32'(req_ready), 32'(1 << order[g]));
      tick();
      check($sformatf("rr%0d_exec_ready", g), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("rr%0d_resp_ready", g), 32'(req_ready), 32'd0);
      check($sformatf("rr%0d_id", g), 32'(rsp_id), 32'(order[g]));
      check($sformatf("rr%0d_c", g), 32'(rsp_c), 32'(11 + order[g]));
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    set_req(1, 3'b000, 8'd40, 8'd2);
    req_valid = 4'b0010;
    #1;
    check("stall_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    for (int s = 0; s < 5; s++) begin
      check($sformatf("stall%0d_valid", s), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d_c", s), 32'(rsp_c), 32'd42);
      check($sformatf("stall%0d_id", s), 32'(rsp_id), 32'd1);
      check($sformatf("stall%0d_ready", s), 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    check("after_release_valid", 32'(rsp_valid), 32'd0);
    check("after_release_grant", 32'(req_ready), 32'b1000);
    check("after_release_c_hold", 32'(rsp_c), 32'd42);
    tick();
    req_valid = '0;
    tick();
    check("pending_id", 32'(rsp_id), 32'd3);
    check("pending_c", 32'(rsp_c), 32'd14);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    set_req(2, 3'b001, 8'd9, 8'd4);
    req_valid = 4'b0100;
    #1;
    check("abort_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_c", 32'(rsp_c), 32'd0);
    req_valid = 4'hF;
    #1;
    check("abort_next_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    for (int w = 0; w < 4; w++) begin
      tick();
      check($sformatf("abort_quiet%0d", w), 32'(rsp_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand and result width in bits.
REQ-002 SHALL have parameter NREQ, default 4, meaning number of requesters (legal range 1..8).
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, NREQ, meaning requester i has an operation pending.
REQ-006 SHALL have port req_ready, output, NREQ, meaning one-hot grant; handshake completes when valid and ready are both high.
REQ-007 SHALL have port req_sel, input, 3*NREQ, giving requester i's opcode in slice [3i+2:3i].
REQ-008 SHALL have ports req_a and req_b, input, N*NREQ each, giving requester i's operands in slice [N*i+N-1:N*i].
REQ-009 SHALL have port rsp_valid, output, 1, meaning a result is presented.
REQ-010 SHALL have port rsp_ready, input, 1, meaning the consumer accepts the result.
REQ-011 SHALL have port rsp_id, output, $clog2(NREQ) (minimum 1), giving the index of the originating requester.
REQ-012 SHALL have port rsp_c, output, N, the result.
REQ-013 SHALL have port rsp_z, output, 1, high when rsp_c == 0.
REQ-014 SHALL have port rsp_err, output, 1, the divide-by-zero flag (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-016 IDLE SHALL assert req_ready combinationally for exactly one requester when any req_valid is high, chosen round-robin starting at index last_grant+1 and wrapping at NREQ-1 to 0.
REQ-017 On handshake, SHALL latch sel, a, b and the id, update last_grant to the granted index, and go to EXEC.
REQ-018 EXEC SHALL last exactly one cycle: apply the latched operands to the ALU, register C, Z and err into the rsp_* registers, and go to RESP.
REQ-019 RESP SHALL hold rsp_valid=1 with all rsp_* stable until rsp_ready=1, then go to IDLE. No new grant is issued in that same cycle.
REQ-020 Latency SHALL be: handshake in cycle t gives rsp_valid=1 in cycle t+2; peak throughput is one operation per 3 cycles.
REQ-021 req_ready SHALL be all-zero in EXEC and RESP; withdrawing req_valid before it is granted is legal and SHALL have no effect.
REQ-022 Opcodes SHALL be: 000 add, 001 sub, 010 mul, 011 div, 100 mod, others pass A. Results are truncated to N bits; sub wraps modulo 2^N.
REQ-023 rsp_c, rsp_z, rsp_id and rsp_err SHALL remain unchanged outside EXEC.

Reset
REQ-024 On rst, SHALL enter IDLE with rsp_valid=0, rsp_c=0, rsp_z=0, rsp_id=0, rsp_err=0, and last_grant=NREQ-1, so requester 0 has first priority.
REQ-025 rst in EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.

Configuration
REQ-026 Macro ALU_ARB_DIVZERO_EN defined: for opcodes 011/100 with b==0, SHALL set rsp_err=1 and rsp_c={N{1'b1}}, with rsp_z=0.
REQ-027 Macro ALU_ARB_DIVZERO_EN undefined: rsp_err SHALL be tied 0 and rsp_c SHALL be the raw ALU output. Divide-by-zero is then the caller's responsibility.

Structure
REQ-028 Package alu_arb_pkg SHALL hold: the state enum typedef, the opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD), and a round-robin next-grant function.
REQ-029 SHALL instantiate exactly one sub-module, alu (parameter N, ports sel/A/B/C/Z), fed only from the latched operand registers.

Verification
REQ-030 Reset, then req_valid[2]=1, sel=000, a=5, b=7: req_ready=0100 in the same cycle; two cycles later rsp_valid=1, rsp_id=2, rsp_c=12, rsp_z=0.
REQ-031 All four requesters valid continuously, rsp_ready=1: grant order is 0,1,2,3,0 with one grant every 3 cycles.
REQ-032 sel=001, a=3, b=3 gives rsp_c=0, rsp_z=1. sel=001, a=0, b=1 (N=8) gives rsp_c=8'hFF, rsp_z=0.
REQ-033 rsp_ready held 0 for 5 cycles in RESP: rsp_* stay stable and req_ready stays 0 throughout; on release, return to IDLE, with the next grant one cycle later.
REQ-034 sel=011, a=9, b=0: with ALU_ARB_DIVZERO_EN, rsp_err=1 and rsp_c=8'hFF; without it, rsp_err=0.
REQ-035 rst asserted in EXEC: the next cycle is IDLE with rsp_valid=0, no response is ever issued for that operation, and requester 0 wins the next simultaneous request.
